nasti_rw_sched: RTL and testbench
=================================

NASTI_RW_SCHED -- requirements
Module: nasti_rw_sched

Interface
REQ-001 SHALL have parameter C_NASTI_ID_WIDTH, default 9, meaning AXI ID width.
REQ-002 SHALL have parameter C_NASTI_ADDR_WIDTH, default 16, meaning byte address width.
REQ-003 SHALL have parameter C_NASTI_DATA_WIDTH, default 64, meaning data beat width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive same-direction grants while the other direction waits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port nasti, nasti_if.slave, with parameters as above: the AW, AR, W and B channels are used; R is driven by the datapath.
REQ-008 SHALL have port cmd_valid, output, 1 bit: command request to the DDR core.
REQ-009 SHALL have port cmd_ready, input, 1 bit: DDR core accepts the command.
REQ-010 SHALL have port cmd_we, output, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port cmd_addr, output, C_NASTI_ADDR_WIDTH bits: burst start address.
REQ-012 SHALL have port cmd_len, output, 8 bits: AXI len (number of beats minus one).
REQ-013 SHALL have port cmd_id, output, C_NASTI_ID_WIDTH bits: transaction ID.
REQ-014 SHALL have port wd_valid / wd_ready / wd_data / wd_strb, out / in / out / out, 1 / 1 / DATA / DATA/8 bits: write-beat stream to the DDR core.

Function
REQ-015 SHALL run the FSM IDLE -> {RD_CMD | WR_CMD} ; RD_CMD -> IDLE ; WR_CMD -> WR_DATA -> WR_RESP -> IDLE.
REQ-016 In IDLE, SHALL grant AR or AW when valid; with both valid, SHALL grant the direction not granted last (alternating round-robin); the first tie after reset goes to read.
REQ-017 On a grant, SHALL assert ar_ready or aw_ready for exactly that one cycle and latch addr, len and id into command registers.
REQ-018 In RD_CMD/WR_CMD, SHALL hold cmd_valid=1 with stable fields until cmd_ready is seen, then leave the state; on the latched cycle, cmd_we = 1 for a write and 0 for a read.
REQ-019 In WR_DATA, SHALL pass W to wd_* combinationally (wd_valid=w_valid, w_ready=wd_ready) and count accepted beats from 0 to len.
REQ-020 SHALL set an error flag if w_last=1 on any beat other than beat len, or w_last=0 on beat len; it SHALL leave WR_DATA after beat len regardless of w_last.
REQ-021 In WR_RESP, SHALL drive b_valid=1, b_id equal to the latched id, and b_resp=2'b00 (OKAY) or 2'b10 (SLVERR) if the error flag is set, and hold them until b_ready.
REQ-022 SHALL never assert aw_ready, ar_ready or w_ready outside the states named above; w_ready=0 outside WR_DATA.
REQ-023 SHALL accept a new grant no earlier than the cycle after returning to IDLE (one idle cycle minimum between transactions).
REQ-024 Latency: aw/ar handshake at cycle N -> cmd_valid at N+1.

Reset
REQ-025 On rst, SHALL go to IDLE and clear cmd_valid, b_valid, aw_ready, ar_ready, w_ready, wd_valid, the beat counter, the error flag, the starvation counter and last-grant (=write, so the first tie goes to read); a reset mid-transaction abandons it with no B response.

Configuration
REQ-026 With NASTI_RW_SCHED_STARVE_EN defined, SHALL replace alternation with same-direction priority (continue the last direction while it is valid), forcing the other direction after STARVE_LIMIT consecutive grants while it waits; the counter clears when the direction switches or the other side is idle.
REQ-027 Without NASTI_RW_SCHED_STARVE_EN, SHALL use only the alternation of REQ-016, with no counter in the logic.

Structure
REQ-028 SHALL place the FSM state enum and the NASTI response constants (OKAY=2'b00, SLVERR=2'b10) in shared package nasti_pkg.
REQ-029 SHALL put the tie-break/starvation decision in one sub-module, nasti_rw_arb (inputs rd_req, wr_req, grant_en; outputs gnt_rd, gnt_wr).

Verification
REQ-030 Single read (ar_addr=0x100, len=3, id=5) -> cmd_valid with cmd_we=0, addr=0x100, len=3, id=5 one cycle after the handshake; no B.
REQ-031 Write with len=1, two beats, w_last on beat 1 -> two wd beats with matching data/strb; b_id echoed; b_resp=OKAY.
REQ-032 Write with len=2 and w_last on beat 1 -> three beats consumed; b_resp=SLVERR.
REQ-033 AW and AR valid continuously for 8 grants, STARVE_EN undefined -> R,W,R,W,...; with STARVE_EN and STARVE_LIMIT=4 -> at most 4 consecutive same-direction grants.
REQ-034 Back-pressure: cmd_ready=0 for 5 cycles, then b_ready=0 for 3 cycles -> fields stable throughout, no new aw/ar_ready.
REQ-035 rst asserted during WR_DATA -> next cycle IDLE, all outputs at reset values, and the next AR is served normally.

Source files
------------

// File: rtl/nasti_pkg.sv
// Shared NASTI definitions: scheduler FSM states and B-channel response codes.
package nasti_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_WR_CMD  = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } sched_state_e;

    localparam logic [1:0] NASTI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] NASTI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/nasti_if.sv
// NASTI (AXI4) bundle; the scheduler is the slave for AW/W/B/AR, R belongs to the datapath.
interface nasti_if #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 16,
    parameter int C_NASTI_DATA_WIDTH = 64
);
    logic                            aw_valid;
    logic                            aw_ready;
    logic [C_NASTI_ID_WIDTH-1:0]     aw_id;
    logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                      aw_len;

    logic                            w_valid;
    logic                            w_ready;
    logic [C_NASTI_DATA_WIDTH-1:0]   w_data;
    logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb;
    logic                            w_last;

    logic                            b_valid;
    logic                            b_ready;
    logic [C_NASTI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                      b_resp;

    logic                            ar_valid;
    logic                            ar_ready;
    logic [C_NASTI_ID_WIDTH-1:0]     ar_id;
    logic [C_NASTI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                      ar_len;

    logic                            r_valid;
    logic                            r_ready;
    logic [C_NASTI_ID_WIDTH-1:0]     r_id;
    logic [C_NASTI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                      r_resp;
    logic                            r_last;

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, output aw_ready,
        input  w_valid, w_data, w_strb, w_last,  output w_ready,
        output b_valid, b_id, b_resp,            input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, output ar_ready
    );

    modport datapath (
        output r_valid, r_id, r_data, r_resp, r_last, input r_ready
    );

endinterface

// File: rtl/nasti_rw_arb.sv
// Read/write grant arbiter: alternating round-robin, or same-direction priority with a
// starvation limit when NASTI_RW_SCHED_STARVE_EN is defined.
module nasti_rw_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_req,
    input  logic wr_req,
    input  logic grant_en,
    output logic gnt_rd,
    output logic gnt_wr
);

    logic last_wr_q, last_wr_d;
    logic pick_wr;

`ifdef NASTI_RW_SCHED_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fresh_q, fresh_d;
    logic             other_wait;

    // Stick with the last direction until it has won STARVE_LIMIT ties in a row.
    always_comb begin
        pick_wr = last_wr_q;
        if (fresh_q) begin
            pick_wr = 1'b0;
        end else if (int'(cnt_q) >= STARVE_LIMIT - 1) begin
            pick_wr = !last_wr_q;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        fresh_d    = fresh_q;
        other_wait = gnt_wr ? rd_req : wr_req;
        if (gnt_rd || gnt_wr) begin
            fresh_d = 1'b0;
            if (!fresh_q && (gnt_wr == last_wr_q) && other_wait) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fresh_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
        end
    end
`else
    assign pick_wr = !last_wr_q;
`endif

    assign gnt_rd = grant_en && rd_req && (!wr_req || !pick_wr);
    assign gnt_wr = grant_en && wr_req && (!rd_req || pick_wr);

    always_comb begin
        last_wr_d = last_wr_q;
        if (gnt_wr) begin
            last_wr_d = 1'b1;
        end else if (gnt_rd) begin
            last_wr_d = 1'b0;
        end
    end

    // Reset to "last was write" so the first tie goes to read.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_q <= 1'b1;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: rtl/nasti_rw_sched.sv
// NASTI read/write command scheduler feeding a DDR core; optional starvation-limited
// arbitration is enabled with NASTI_RW_SCHED_STARVE_EN.
module nasti_rw_sched #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 16,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    nasti_if.slave                          nasti,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_we,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [7:0]                      cmd_len,
    output logic [C_NASTI_ID_WIDTH-1:0]     cmd_id,
    output logic                            wd_valid,
    input  logic                            wd_ready,
    output logic [C_NASTI_DATA_WIDTH-1:0]   wd_data,
    output logic [C_NASTI_DATA_WIDTH/8-1:0] wd_strb
);
    import nasti_pkg::*;

    sched_state_e                  state_q, state_d;
    logic [C_NASTI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                    len_q, len_d;
    logic [C_NASTI_ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]                    beat_q, beat_d;
    logic                          err_q, err_d;
    logic                          gap_q, gap_d;
    logic                          grant_en, gnt_rd, gnt_wr, w_fire, last_beat;

    // The first IDLE cycle after a transaction is a dead cycle: no new grant.
    assign grant_en = (state_q == ST_IDLE) && !gap_q;

    nasti_rw_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (nasti.ar_valid),
        .wr_req   (nasti.aw_valid),
        .grant_en (grant_en),
        .gnt_rd   (gnt_rd),
        .gnt_wr   (gnt_wr)
    );

    assign nasti.ar_ready = gnt_rd;
    assign nasti.aw_ready = gnt_wr;

    assign cmd_valid = (state_q == ST_RD_CMD) || (state_q == ST_WR_CMD);
    assign cmd_we    = (state_q == ST_WR_CMD);
    assign cmd_addr  = addr_q;
    assign cmd_len   = len_q;
    assign cmd_id    = id_q;

    assign wd_valid      = (state_q == ST_WR_DATA) && nasti.w_valid;
    assign nasti.w_ready = (state_q == ST_WR_DATA) && wd_ready;
    assign wd_data       = nasti.w_data;
    assign wd_strb       = nasti.w_strb;
    assign w_fire        = wd_valid && wd_ready;
    assign last_beat     = (beat_q == len_q);

    assign nasti.b_valid = (state_q == ST_WR_RESP);
    assign nasti.b_id    = id_q;
    assign nasti.b_resp  = err_q ? NASTI_RESP_SLVERR : NASTI_RESP_OKAY;

    // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        beat_d  = beat_q;
        err_d   = err_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                gap_d = 1'b0;
                if (gnt_rd) begin
                    state_d = ST_RD_CMD;
                    addr_d  = nasti.ar_addr;
                    len_d   = nasti.ar_len;
                    id_d    = nasti.ar_id;
                end else if (gnt_wr) begin
                    state_d = ST_WR_CMD;
                    addr_d  = nasti.aw_addr;
                    len_d   = nasti.aw_len;
                    id_d    = nasti.aw_id;
                    err_d   = 1'b0;
                end
            end
            ST_RD_CMD: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                    gap_d   = 1'b1;
                end
            end
            ST_WR_CMD: begin
                if (cmd_ready) begin
                    state_d = ST_WR_DATA;
                    beat_d  = '0;
                end
            end
            ST_WR_DATA: begin
                if (w_fire) begin
                    if (nasti.w_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (nasti.b_ready) begin
                    state_d = ST_IDLE;
                    gap_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_nasti_rw_sched.sv
// Directed self-checking bench for nasti_rw_sched (default build; run-length check when
// NASTI_RW_SCHED_STARVE_EN is defined).
module tb_nasti_rw_sched;

    localparam int IDW = 9;
    localparam int AW  = 16;
    localparam int DW  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [IDW-1:0] cmd_id;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic [DW/8-1:0] wd_strb;

    int total = 0;
    int bad   = 0;

    nasti_if #(
        .C_NASTI_ID_WIDTH   (IDW),
        .C_NASTI_ADDR_WIDTH (AW),
        .C_NASTI_DATA_WIDTH (DW)
    ) nasti ();

    assign nasti.r_valid = 1'b0;
    assign nasti.r_id    = '0;
    assign nasti.r_data  = '0;
    assign nasti.r_resp  = 2'b00;
    assign nasti.r_last  = 1'b0;
    assign nasti.r_ready = 1'b0;

    nasti_rw_sched #(
        .C_NASTI_ID_WIDTH   (IDW),
        .C_NASTI_ADDR_WIDTH (AW),
        .C_NASTI_DATA_WIDTH (DW),
        .STARVE_LIMIT       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nasti     (nasti),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_id    (cmd_id),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .wd_strb   (wd_strb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 ns after the edge, sampling 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run;
        int max_run;
        int prev;
        int dir;

        rst = 1'b1;
        cmd_ready = 1'b0;
        wd_ready = 1'b0;
        nasti.aw_valid = 1'b0; nasti.aw_id = '0; nasti.aw_addr = '0; nasti.aw_len = '0;
        nasti.ar_valid = 1'b0; nasti.ar_id = '0; nasti.ar_addr = '0; nasti.ar_len = '0;
        nasti.w_valid = 1'b0; nasti.w_data = '0; nasti.w_strb = '0; nasti.w_last = 1'b0;
        nasti.b_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_b_valid", nasti.b_valid, 0);
        check("rst_aw_ready", nasti.aw_ready, 0);
        check("rst_ar_ready", nasti.ar_ready, 0);
        check("rst_w_ready", nasti.w_ready, 0);
        check("rst_wd_valid", wd_valid, 0);

        // Single read.
        nasti.ar_valid = 1'b1; nasti.ar_addr = 16'h0100; nasti.ar_len = 8'd3; nasti.ar_id = 9'd5;
        #1;
        check("rd_ar_ready", nasti.ar_ready, 1);
        check("rd_aw_ready", nasti.aw_ready, 0);
        tick();
        nasti.ar_valid = 1'b0;
        #1;
        check("rd_cmd_valid", cmd_valid, 1);
        check("rd_cmd_we", cmd_we, 0);
        check("rd_cmd_addr", cmd_addr, 64'h100);
        check("rd_cmd_len", cmd_len, 3);
        check("rd_cmd_id", cmd_id, 5);
        check("rd_ar_ready_drop", nasti.ar_ready, 0);
        check("rd_no_b", nasti.b_valid, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Write, len=1, correct w_last; first probe lands on the dead idle cycle.
        nasti.aw_valid = 1'b1; nasti.aw_addr = 16'h0200; nasti.aw_len = 8'd1; nasti.aw_id = 9'h1A3;
        #1;
        check("rd_done_cmd_valid", cmd_valid, 0);
        check("gap_aw_ready", nasti.aw_ready, 0);
        tick();
        check("wr1_aw_ready", nasti.aw_ready, 1);
        tick();
        nasti.aw_valid = 1'b0;
        nasti.w_valid = 1'b1; wd_ready = 1'b1;
        nasti.w_data = 64'hDEAD_BEEF_0000_0001; nasti.w_strb = 8'hFF; nasti.w_last = 1'b0;
        #1;
        check("wr1_cmd_valid", cmd_valid, 1);
        check("wr1_cmd_we", cmd_we, 1);
        check("wr1_cmd_addr", cmd_addr, 64'h200);
        check("wr1_cmd_len", cmd_len, 1);
        check("wr1_cmd_id", cmd_id, 64'h1A3);
        check("wr1_w_ready_in_cmd", nasti.w_ready, 0);
        check("wr1_wd_valid_in_cmd", wd_valid, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        #1;
        check("wr1_b0_wd_valid", wd_valid, 1);
        check("wr1_b0_w_ready", nasti.w_ready, 1);
        check("wr1_b0_data", wd_data, 64'hDEAD_BEEF_0000_0001);
        check("wr1_b0_strb", wd_strb, 64'hFF);
        tick();
        nasti.w_data = 64'h1234_5678_9ABC_DEF0; nasti.w_strb = 8'h0F; nasti.w_last = 1'b1;
        #1;
        check("wr1_b1_wd_valid", wd_valid, 1);
        check("wr1_b1_data", wd_data, 64'h1234_5678_9ABC_DEF0);
        check("wr1_b1_strb", wd_strb, 64'h0F);
        tick();
        nasti.w_valid = 1'b0; nasti.w_last = 1'b0;
        #1;
        check("wr1_b_valid", nasti.b_valid, 1);
        check("wr1_b_id", nasti.b_id, 64'h1A3);
        check("wr1_b_resp", nasti.b_resp, 2'b00);
        check("wr1_w_ready_in_resp", nasti.w_ready, 0);
        nasti.b_ready = 1'b1;
        tick();
        nasti.b_ready = 1'b0;
        #1;
        check("wr1_b_done", nasti.b_valid, 0);

        // Write, len=2 with early w_last, plus command and response back-pressure.
        nasti.aw_valid = 1'b1; nasti.aw_addr = 16'h0300; nasti.aw_len = 8'd2; nasti.aw_id = 9'd7;
        tick();
        check("wr2_aw_ready", nasti.aw_ready, 1);
        tick();
        nasti.aw_addr = 16'h0999; nasti.aw_len = 8'd9; nasti.aw_id = 9'd1;
        nasti.ar_valid = 1'b1; nasti.ar_addr = 16'h0777;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_valid", cmd_valid, 1);
            check("bp_cmd_we", cmd_we, 1);
            check("bp_cmd_addr", cmd_addr, 64'h300);
            check("bp_cmd_len", cmd_len, 2);
            check("bp_cmd_id", cmd_id, 7);
            check("bp_aw_ready", nasti.aw_ready, 0);
            check("bp_ar_ready", nasti.ar_ready, 0);
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        nasti.w_valid = 1'b1; wd_ready = 1'b0;
        nasti.w_data = 64'hA0; nasti.w_strb = 8'h01; nasti.w_last = 1'b0;
        #1;
        check("wr2_stall_w_ready", nasti.w_ready, 0);
        check("wr2_stall_wd_valid", wd_valid, 1);
        tick();
        wd_ready = 1'b1;
        #1;
        check("wr2_b0_w_ready", nasti.w_ready, 1);
        tick();
        nasti.w_data = 64'hA1; nasti.w_last = 1'b1;
        tick();
        nasti.w_data = 64'hA2; nasti.w_last = 1'b0;
        #1;
        check("wr2_b2_wd_valid", wd_valid, 1);
        check("wr2_b2_data", wd_data, 64'hA2);
        tick();
        nasti.w_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_b_valid", nasti.b_valid, 1);
            check("bp_b_resp", nasti.b_resp, 2'b10);
            check("bp_b_id", nasti.b_id, 7);
            check("bp_b_aw_ready", nasti.aw_ready, 0);
            check("bp_b_ar_ready", nasti.ar_ready, 0);
            tick();
        end
        nasti.b_ready = 1'b1;
        tick();

        // Both directions valid continuously: observe 8 grants.
        nasti.aw_len = 8'd0; nasti.ar_len = 8'd0;
        cmd_ready = 1'b1; wd_ready = 1'b1;
        nasti.w_valid = 1'b1; nasti.w_last = 1'b1;
        #1;
        n = 0; run = 0; max_run = 0; prev = -1;
        for (int c = 0; c < 100 && n < 8; c++) begin
            if (nasti.ar_ready || nasti.aw_ready) begin
                check("arb_single_grant", nasti.ar_ready & nasti.aw_ready, 0);
                dir = nasti.aw_ready ? 1 : 0;
`ifndef NASTI_RW_SCHED_STARVE_EN
                check("arb_alternate", dir, n % 2);
`endif
                run = (dir == prev) ? run + 1 : 1;
                if (run > max_run) max_run = run;
                prev = dir;
                n++;
            end
            if (n < 8) tick();
        end
        check("arb_grant_count", n, 8);
`ifdef NASTI_RW_SCHED_STARVE_EN
        check("arb_max_run_le4", max_run <= 4, 1);
`else
        check("arb_max_run", max_run, 1);
`endif
        nasti.ar_valid = 1'b0; nasti.aw_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        nasti.w_valid = 1'b0; nasti.w_last = 1'b0;
        nasti.b_ready = 1'b0; cmd_ready = 1'b0;

        // Reset in the middle of WR_DATA.
        nasti.aw_valid = 1'b1; nasti.aw_addr = 16'h0500; nasti.aw_len = 8'd3; nasti.aw_id = 9'd9;
        #1;
        check("rstw_aw_ready", nasti.aw_ready, 1);
        tick();
        nasti.aw_valid = 1'b0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        nasti.w_valid = 1'b1; wd_ready = 1'b1; nasti.w_data = 64'h55; nasti.w_strb = 8'hFF;
        #1;
        check("rstw_b0_w_ready", nasti.w_ready, 1);
        tick();
        check("rstw_b1_w_ready", nasti.w_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstw_cmd_valid", cmd_valid, 0);
        check("rstw_b_valid", nasti.b_valid, 0);
        check("rstw_w_ready", nasti.w_ready, 0);
        check("rstw_wd_valid", wd_valid, 0);
        check("rstw_aw_ready", nasti.aw_ready, 0);
        check("rstw_ar_ready", nasti.ar_ready, 0);
        nasti.w_valid = 1'b0;
        nasti.ar_valid = 1'b1; nasti.ar_addr = 16'h0040; nasti.ar_len = 8'd0; nasti.ar_id = 9'd3;
        nasti.aw_valid = 1'b1;
        #1;
        check("post_rst_tie_ar", nasti.ar_ready, 1);
        check("post_rst_tie_aw", nasti.aw_ready, 0);
        tick();
        nasti.ar_valid = 1'b0; nasti.aw_valid = 1'b0;
        #1;
        check("post_rst_cmd_valid", cmd_valid, 1);
        check("post_rst_cmd_we", cmd_we, 0);
        check("post_rst_cmd_addr", cmd_addr, 64'h40);
        check("post_rst_cmd_id", cmd_id, 3);
        check("post_rst_no_b", nasti.b_valid, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        #1;
        check("post_rst_done", cmd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
